// File: rtl/load_store_unit_if.sv
// Memory-side bus of the load/store unit: request/ready handshake with a
// wait-state data memory. The LSU is the master, the memory the slave.
interface load_store_unit_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  ready, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output ready, rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit. Takes the ALU result as the effective address,
// checks alignment/encoding, steers byte lanes and replicates store data,
// runs the req/ready handshake with the data memory and sign/zero extends
// load results. Stalls the core until the access completes or faults.
// Optional feature: define LSU_TIMEOUT_EN to abort requests that wait
// TIMEOUT_CYCLES cycles without mem ready, reporting bus_error.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic        done,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        bus_error,
  load_store_unit_if.master mem
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t      state, state_next;
  logic        illegal;
  logic        accept;
  logic        timeout_hit;
  logic        load_flag;
  logic [1:0]  addr_lo;
  logic [2:0]  funct3_q;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  // Illegal-access detection: direction ambiguity, bad funct3, misalignment.
  always_comb begin
    illegal = 1'b0;
    if (is_load == is_store) begin
      illegal = 1'b1;
    end else if (is_load) begin
      case (funct3)
        3'b000, 3'b100: illegal = 1'b0;
        3'b001, 3'b101: illegal = address[0];
        3'b010:         illegal = (address[1:0] != 2'b00);
        default:        illegal = 1'b1;
      endcase
    end else begin
      case (funct3)
        3'b000:  illegal = 1'b0;
        3'b001:  illegal = address[0];
        3'b010:  illegal = (address[1:0] != 2'b00);
        default: illegal = 1'b1;
      endcase
    end
  end

  assign accept = (state == IDLE) && start && !illegal;

  // Byte-enable generation and store-data lane replication from width field.
  always_comb begin
    be_next    = 4'b1111;
    wdata_next = store_data;
    case (funct3[1:0])
      2'b00: begin
        be_next    = 4'b0001 << address[1:0];
        wdata_next = {4{store_data[7:0]}};
      end
      2'b01: begin
        be_next    = 4'b0011 << address[1:0];
        wdata_next = {2{store_data[15:0]}};
      end
      default: begin
        be_next    = 4'b1111;
        wdata_next = store_data;
      end
    endcase
  end

  // Load lane extraction and extension using the offset captured at REQ entry.
  always_comb begin
    byte_sel = 8'h00;
    case (addr_lo)
      2'd0: byte_sel = mem.rdata[7:0];
      2'd1: byte_sel = mem.rdata[15:8];
      2'd2: byte_sel = mem.rdata[23:16];
      default: byte_sel = mem.rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? mem.rdata[31:16] : mem.rdata[15:0];
    case (funct3_q)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_ext = {24'h000000, byte_sel};
      3'b101:  load_ext = {16'h0000, half_sel};
      default: load_ext = mem.rdata;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] count;
  logic       timeout_flag;

  // Wait counter: cleared on REQ entry, counts REQ cycles without ready;
  // timeout_flag remembers whether the coming FAULT is a bus error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count        <= 8'd0;
      timeout_flag <= 1'b0;
    end else if (accept) begin
      count        <= 8'd0;
      timeout_flag <= 1'b0;
    end else if (state == IDLE) begin
      timeout_flag <= 1'b0;
    end else if (state == REQ && !mem.ready) begin
      count        <= count + 8'd1;
      timeout_flag <= timeout_hit;
    end
  end

  // Terminal count only aborts when ready is absent in that same cycle.
  assign timeout_hit = (count == TIMEOUT_LAST) && !mem.ready;
  assign misaligned  = (state == FAULT) && !timeout_flag;
  assign bus_error   = (state == FAULT) && timeout_flag;
`else
  // TIMEOUT_CYCLES has no effect in this build; keep it referenced.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
  end

  assign timeout_hit = 1'b0;
  assign misaligned  = (state == FAULT);
  assign bus_error   = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) state_next = illegal ? FAULT : REQ;
      end
      REQ: begin
        if (mem.ready)        state_next = DONE;
        else if (timeout_hit) state_next = FAULT;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request attributes are captured once at REQ entry and held; load data
  // is updated only when a load completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem.we    <= 1'b0;
      mem.addr  <= 32'h0;
      mem.be    <= 4'h0;
      mem.wdata <= 32'h0;
      load_flag <= 1'b0;
      addr_lo   <= 2'b00;
      funct3_q  <= 3'b000;
      load_data <= 32'h0;
    end else begin
      if (accept) begin
        mem.we    <= is_store;
        mem.addr  <= {address[31:2], 2'b00};
        mem.be    <= be_next;
        mem.wdata <= wdata_next;
        load_flag <= is_load;
        addr_lo   <= address[1:0];
        funct3_q  <= funct3;
      end
      if (state == REQ && mem.ready && load_flag) begin
        load_data <= load_ext;
      end
    end
  end

  // Status outputs decode directly from the state register.
  assign mem.req = (state == REQ);
  assign done    = (state == DONE);
  // Stall is forced low during reset so the core is never frozen by it.
  assign stall   = reset && (((state == IDLE) && start) || (state == REQ));

endmodule
